// File: rtl/axi_fifo_pkg.sv
// Shared types for the async FIFO write-side front end.
// State encoding and AXI response codes.
package axi_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } ingress_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_wr_ingress.sv
// AXI4 write slave feeding the async FIFO write port.
// One burst at a time; flush drops the rest and answers SLVERR.
module axi_wr_ingress
  import axi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  w_clk,
  input  logic                  wresetn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [LEN_WIDTH-1:0]  awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  input  logic                  flush,
  input  logic                  full,
  output logic                  wr_enable,
  output logic [DATA_WIDTH-1:0] wr_data
);

  ingress_state_t         state;
  logic [ID_WIDTH-1:0]    id_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_cnt;
  logic                   err;
  logic                   drop;

  logic in_data;
  logic drop_now;
  logic accept;
  logic last_beat;
  logic wlast_bad;

  assign in_data   = (state == DATA);
  assign drop_now  = drop | flush;
  assign wready    = in_data & (drop_now | ~full);
  assign accept    = wvalid & wready;
  assign last_beat = (beat_cnt == len_q);
  assign wlast_bad = (wlast != last_beat);

  assign awready   = (state == IDLE);
  assign bvalid    = (state == RESP);
  assign wr_enable = accept & ~drop_now;
  assign wr_data   = wdata;

  // Burst FSM, beat counter, error/drop flags and B response
  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      state    <= IDLE;
      id_q     <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
      drop     <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      unique case (state)
        IDLE: begin
          if (awvalid) begin
            id_q     <= awid;
            len_q    <= awlen;
            beat_cnt <= '0;
            err      <= 1'b0;
            drop     <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (flush) begin
            drop <= 1'b1;
            err  <= 1'b1;
          end
          if (accept) begin
            if (wlast_bad)
              err <= 1'b1;
            if (last_beat) begin
              state <= RESP;
              bid   <= id_q;
              bresp <= (err | flush | wlast_bad)
                       ? RESP_SLVERR : RESP_OKAY;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          if (bready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
